// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared PIO register addresses and edge-type codes
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_in_edge_capture_if.sv
// rtl/pio_in_edge_capture_if.sv - Avalon-MM slave register bus for the input PIO
interface pio_in_edge_capture_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_sync_bus.sv
// rtl/pio_sync_bus.sv - per-bit flop chain synchronizer with async reset to 0
module pio_sync_bus #(
  parameter int WIDTH       = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* async_reg = "true" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // Shift the asynchronous bus through SYNC_STAGES flops, all cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pio_in_edge_capture.sv
// rtl/pio_in_edge_capture.sv - input PIO with per-bit edge capture and maskable level irq
module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int WIDTH       = 27,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_in_edge_capture_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] prev_data;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic             wr_en;
  logic [31:0]      rd_mux;

  pio_sync_bus #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_data)
  );

  // Remember last cycle's synchronized value for edge comparison.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_data <= '0;
    else          prev_data <= sync_data;
  end

  assign rise = sync_data & ~prev_data;
  assign fall = ~sync_data & prev_data;

  // Pick which transitions count as events for this instance.
  always_comb begin
    edge_event = rise;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_event = fall;
      EDGE_ANY:     edge_event = rise | fall;
      default:      edge_event = rise;
    endcase
  end

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign edge_clr = (wr_en && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  // Sticky edge bits: write-1-to-clear, a same-cycle event wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~edge_clr) | edge_event;
  end

  // Interrupt enable mask, loaded from the low WIDTH bits of writedata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   irq_mask <= '0;
    else if (wr_en && bus.address == PIO_ADDR_IRQMASK) irq_mask <= bus.writedata[WIDTH-1:0];
  end

  assign irq = |(edge_capture & irq_mask);

  // Zero-extended register select; unmapped address 1 reads 0.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_data;
      PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:          rd_mux = '0;
    endcase
  end

  // Read data is registered (latency 1) and returns pre-write state; idle bus reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            bus.readdata <= '0;
    else if (bus.chipselect) bus.readdata <= rd_mux;
    else                     bus.readdata <= '0;
  end

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// tb/tb_pio_in_edge_capture.sv - self-checking bench for pio_in_edge_capture
module tb_pio_in_edge_capture;

  logic        clk;
  logic        reset_n;
  logic [26:0] in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic        irq0, irq1, irq2;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int          dut;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [26:0] in_val;
    logic        wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  pio_in_edge_capture_if bus0 ();
  pio_in_edge_capture_if bus1 ();
  pio_in_edge_capture_if bus2 ();

  assign bus0.address = address;  assign bus0.chipselect = chipselect;
  assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
  assign bus1.address = address;  assign bus1.chipselect = chipselect;
  assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
  assign bus2.address = address;  assign bus2.chipselect = chipselect;
  assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

  pio_in_edge_capture #(.WIDTH(27), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));
  pio_in_edge_capture #(.WIDTH(27), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq1));
  pio_in_edge_capture #(.WIDTH(27), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd_of(int d);
    case (d)
      1:       return bus1.readdata;
      2:       return bus2.readdata;
      default: return bus0.readdata;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Push the expectation when the read is issued, pop it when readdata is produced.
  task automatic sb_pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check(e.name, rd_of(e.dut), e.exp);
    end
  endtask

  task automatic bus_read(int d, logic [1:0] a, logic [31:0] exp, string name);
    sb_t e;
    e.dut = d; e.exp = exp; e.name = name;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    sb_q.push_back(e);
    tick();
    chipselect = 1'b0;
    sb_pop_check();
  endtask

  initial begin
    sb_t e;

    vecs[0] = '{27'h20,      1'b1, 2'd0, 32'hFFFFFFFF, 2'd0, 32'h00000020};
    vecs[1] = '{27'h20,      1'b1, 2'd2, 32'hFFFFFFFF, 2'd2, 32'h07FFFFFF};
    vecs[2] = '{27'h20,      1'b1, 2'd1, 32'hFFFFFFFF, 2'd1, 32'h00000000};
    vecs[3] = '{27'h7FFFFFF, 1'b0, 2'd0, 32'h0,        2'd0, 32'h07FFFFFF};
    vecs[4] = '{27'h1234567, 1'b1, 2'd2, 32'hF0001234, 2'd2, 32'h00001234};
    vecs[5] = '{27'h0,       1'b1, 2'd3, 32'hFFFFFFFF, 2'd3, 32'h00000000};
    vecs[6] = '{27'h4000000, 1'b0, 2'd0, 32'h0,        2'd3, 32'h04000000};
    vecs[7] = '{27'h0,       1'b1, 2'd3, 32'h04000000, 2'd3, 32'h00000000};

    // Reset state, in_port already driven during reset
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 27'h5A5A5A;
    #3;
    check("reset_readdata", bus0.readdata, 32'h0);
    check("reset_irq", {29'h0, irq2, irq1, irq0}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // First cycle out of reset: nothing captured yet
    bus_read(0, 2'd3, 32'h0, "edgecap_after_reset");
    ticks(2);
    bus_read(0, 2'd0, 32'h005A5A5A, "data_after_sync");
    bus_read(0, 2'd3, 32'h005A5A5A, "rise_from_reset_level");
    bus_read(1, 2'd3, 32'h0, "no_fall_from_reset_level");
    in_port = 27'h0;
    ticks(4);
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_read(0, 2'd3, 32'h0, "clear_all_dut0");
    bus_read(2, 2'd3, 32'h0, "clear_all_dut2");

    // Rising edge with mask off, then unmask and clear
    in_port = 27'h8;
    ticks(4);
    bus_read(0, 2'd3, 32'h8, "edgecap_bit3");
    check("irq_masked", {31'h0, irq0}, 32'h0);
    bus_write(2'd2, 32'h8);
    check("irq_unmasked", {31'h0, irq0}, 32'h1);
    bus_write(2'd3, 32'h8);
    check("irq_after_clear", {31'h0, irq0}, 32'h0);
    bus_read(0, 2'd3, 32'h0, "edgecap_cleared");

    // Exact irq latency: SYNC_STAGES+1 cycles
    in_port = 27'h0;
    ticks(4);
    in_port = 27'h8;
    ticks(2);
    check("irq_latency_early", {31'h0, irq0}, 32'h0);
    tick();
    check("irq_latency", {31'h0, irq0}, 32'h1);
    bus_write(2'd2, 32'h0);
    check("irq_mask_off", {31'h0, irq0}, 32'h0);
    bus_write(2'd2, 32'h8);
    bus_write(2'd3, 32'h8);

    // Edge and clear on the same bit in the same cycle: set wins
    in_port = 27'h0;
    ticks(4);
    bus_write(2'd3, 32'hFFFFFFFF);
    in_port = 27'h8;
    ticks(2);
    bus_write(2'd3, 32'h8);
    bus_read(0, 2'd3, 32'h8, "set_wins");
    check("set_wins_irq", {31'h0, irq0}, 32'h1);
    bus_write(2'd3, 32'h8);
    bus_read(0, 2'd3, 32'h0, "set_wins_cleared");

    // Edge types across the three instances
    in_port = 27'h4000000;
    ticks(4);
    bus_write(2'd3, 32'hFFFFFFFF);
    in_port = 27'h4000001;
    ticks(4);
    in_port = 27'h0;
    ticks(4);
    bus_read(2, 2'd3, 32'h04000001, "any_edges");
    bus_read(1, 2'd3, 32'h04000001, "fall_edges");
    bus_read(0, 2'd3, 32'h00000001, "rise_edges");
    in_port = 27'h20;
    ticks(4);
    bus_read(2, 2'd3, 32'h04000021, "any_edges_bit5");
    bus_read(1, 2'd3, 32'h04000001, "fall_ignores_rise");
    bus_read(0, 2'd3, 32'h00000021, "rise_edges_bit5");

    // Read in the same cycle as a write returns the old value
    address = 2'd2; writedata = 32'h3; chipselect = 1'b1; write_n = 1'b0;
    e.dut = 0; e.exp = 32'h8; e.name = "read_before_write";
    sb_q.push_back(e);
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    sb_pop_check();
    bus_read(0, 2'd2, 32'h3, "mask_after_write");
    tick();
    check("idle_readdata", bus0.readdata, 32'h0);

    // Register table
    foreach (vecs[i]) begin
      in_port = vecs[i].in_val;
      ticks(3);
      if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdata);
      bus_read(0, vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-transfer with irq high
    bus_write(2'd2, 32'h8);
    ticks(4);
    in_port = 27'h8;
    ticks(4);
    check("pre_reset_irq", {31'h0, irq0}, 32'h1);
    address = 2'd3; chipselect = 1'b1; write_n = 1'b1;
    tick();
    check("pre_reset_readdata", bus0.readdata, 32'h8);
    #2;
    in_port = 27'h0;
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", {31'h0, irq0}, 32'h0);
    check("async_reset_readdata", bus0.readdata, 32'h0);
    chipselect = 1'b0;
    tick();
    reset_n = 1'b1;
    bus_read(0, 2'd2, 32'h0, "async_reset_mask");
    bus_read(0, 2'd3, 32'h0, "async_reset_edgecap");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
